// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered-read mode.
module fifo_sync_param #(
    parameter int unsigned FIFO_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned AF_THRESH  = FIFO_DEPTH - 1,
    parameter int unsigned AE_THRESH  = 1,
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             almost_full_q, almost_full_d;
    logic             almost_empty_q, almost_empty_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             rd_acc, wr_acc;

    always_comb begin
        rd_acc   = rd_en & ~empty_q;
        // At full a write is still taken when a read frees a slot in the same cycle.
        wr_acc   = wr_en & (~full_q | rd_acc);
        wr_ptr_d = wr_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        full_d         = (32'(count_d) == FIFO_DEPTH);
        empty_d        = (count_d == '0);
        almost_full_d  = (32'(count_d) >= AF_THRESH);
        almost_empty_d = (32'(count_d) <= AE_THRESH);

        overflow_d  = clr_err ? 1'b0 : (overflow_q | (wr_en & ~wr_acc));
        underflow_d = clr_err ? 1'b0 : (underflow_q | (rd_en & ~rd_acc));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    // Storage is not reset; only pointers define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

`ifdef FIFO_FWFT_EN
    assign rd_data = empty_q ? '0 : mem[rd_ptr_q];
`else
    logic [FIFO_WIDTH-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = rd_acc ? mem[rd_ptr_q] : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
`endif

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: an 8x8 instance for the main scenarios and a depth-4
// instance for pointer wrap. Honours FIFO_FWFT_EN for read timing.
module tb_fifo_sync_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr_err;

    logic       wr_en, rd_en;
    logic [7:0] wr_data, rd_data;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;

    logic       w_wr_en, w_rd_en;
    logic [7:0] w_wr_data, w_rd_data;
    logic       w_full, w_empty, w_almost_full, w_almost_empty, w_overflow, w_underflow;
    logic [2:0] w_count;

    int total_cnt = 0;
    int pass_cnt  = 0;

    logic [7:0] pattern [8] = '{8'hFF, 8'hAA, 8'h55, 8'h0F, 8'hF0, 8'h01, 8'h03, 8'h07};

    always #5 clk = ~clk;

    fifo_sync_param #(.FIFO_WIDTH(8), .FIFO_DEPTH(8)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    fifo_sync_param #(.FIFO_WIDTH(8), .FIFO_DEPTH(4)) u_dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (w_wr_en),
        .wr_data      (w_wr_data),
        .rd_en        (w_rd_en),
        .rd_data      (w_rd_data),
        .full         (w_full),
        .empty        (w_empty),
        .almost_full  (w_almost_full),
        .almost_empty (w_almost_empty),
        .count        (w_count),
        .overflow     (w_overflow),
        .underflow    (w_underflow),
        .clr_err      (clr_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Pops one word from the 8x8 instance and checks it against exp.
    task automatic read_word(input string tag, input logic [7:0] exp);
`ifdef FIFO_FWFT_EN
        check(tag, 32'(rd_data), 32'(exp));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
`else
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check(tag, 32'(rd_data), 32'(exp));
`endif
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < 8; i++) write_word(pattern[i]);
    endtask

    initial begin
        logic [7:0] wd;
        logic [7:0] rdx;
        rst_n   = 1'b0;
        clr_err = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'hAB;
        rd_en   = 1'b0;
        w_wr_en = 1'b0;
        w_rd_en = 1'b0;
        w_wr_data = 8'h00;

        // Reset with wr_en held high.
        tick();
        tick();
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_almost_empty", 32'(almost_empty), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_almost_full", 32'(almost_full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        wr_en = 1'b0;
        rst_n = 1'b1;
        tick();

        // Fill and drain.
        for (int i = 0; i < 8; i++) begin
            write_word(pattern[i]);
            if (i == 0) check("fill1_almost_empty", 32'(almost_empty), 32'd1);
            if (i == 1) check("fill2_almost_empty", 32'(almost_empty), 32'd0);
            if (i == 5) check("fill6_almost_full", 32'(almost_full), 32'd0);
            if (i == 6) check("fill7_almost_full", 32'(almost_full), 32'd1);
            if (i == 6) check("fill7_full", 32'(full), 32'd0);
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) read_word("drain_data", pattern[i]);
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_count", 32'(count), 32'd0);
        check("drain_underflow", 32'(underflow), 32'd0);

        // Overflow at full.
        fill_pattern();
        write_word(8'h5A);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) read_word("ovf_drain", pattern[i]);
        check("ovf_empty", 32'(empty), 32'd1);
        check("ovf_sticky", 32'(overflow), 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Simultaneous read+write at full.
        fill_pattern();
        rd_en   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hC3;
        tick();
        rd_en = 1'b0;
        wr_en = 1'b0;
        check("sim_full_count", 32'(count), 32'd8);
        check("sim_full_full", 32'(full), 32'd1);
        check("sim_full_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i < 8; i++) read_word("sim_drain", pattern[i]);
        read_word("sim_last_c3", 8'hC3);
        check("sim_empty", 32'(empty), 32'd1);

        // Simultaneous read+write at empty: read rejected, write taken.
        rd_en   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h3C;
        tick();
        rd_en = 1'b0;
        wr_en = 1'b0;
        check("sim_empty_underflow", 32'(underflow), 32'd1);
        check("sim_empty_count", 32'(count), 32'd1);
        read_word("sim_empty_3c", 8'h3C);
        check("sim_empty_after", 32'(empty), 32'd1);

        // clr_err beats a new underflow in the same cycle.
        rd_en   = 1'b1;
        clr_err = 1'b1;
        tick();
        rd_en   = 1'b0;
        clr_err = 1'b0;
        check("clr_wins", 32'(underflow), 32'd0);
        check("clr_count", 32'(count), 32'd0);

`ifdef FIFO_FWFT_EN
        write_word(8'h11);
        check("fwft_show", 32'(rd_data), 32'h11);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("fwft_pop_empty", 32'(empty), 32'd1);
        check("fwft_pop_zero", 32'(rd_data), 32'd0);
`else
        // Registered output holds its last value with no accepted read.
        check("hold_rd_data", 32'(rd_data), 32'h3C);
        write_word(8'h11);
        check("std_no_fallthrough", 32'(rd_data), 32'h3C);
        read_word("std_read_11", 8'h11);
`endif

        // Mid-operation reset discards contents.
        write_word(8'h77);
        write_word(8'h78);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_empty", 32'(empty), 32'd1);

        // Depth-4 wrap: 3 in, 3 out, ten rounds.
        wd  = 8'h00;
        rdx = 8'h00;
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 3; k++) begin
                w_wr_en   = 1'b1;
                w_wr_data = wd;
                wd++;
                tick();
            end
            w_wr_en = 1'b0;
            check("wrap_count", 32'(w_count), 32'd3);
            check("wrap_not_full", 32'(w_full), 32'd0);
            for (int k = 0; k < 3; k++) begin
`ifdef FIFO_FWFT_EN
                check("wrap_data", 32'(w_rd_data), 32'(rdx));
                w_rd_en = 1'b1;
                tick();
`else
                w_rd_en = 1'b1;
                tick();
                check("wrap_data", 32'(w_rd_data), 32'(rdx));
`endif
                rdx++;
            end
            w_rd_en = 1'b0;
            check("wrap_empty", 32'(w_empty), 32'd1);
        end
        check("wrap_overflow", 32'(w_overflow), 32'd0);
        check("wrap_underflow", 32'(w_underflow), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
